// File: rtl/pps_pkg.sv
// Shared widths, limits and helpers for the PPS phase/frequency measurement block.
package pps_pkg;

    localparam int PPS_CNT_W  = 28;
    localparam int PPS_PH_W   = 29;
    localparam int PPS_NUM_CH = 4;

    typedef logic [PPS_CNT_W-1:0] cnt_t;
    typedef logic [PPS_PH_W-1:0]  ph_t;

    localparam cnt_t PPS_CNT_MAX = 28'hFFFFFFF;

    typedef enum logic {
        ARM_IDLE  = 1'b0,
        ARM_ARMED = 1'b1
    } arm_state_e;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == PPS_CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Bit 28 flags a channel that produced no edge in the window.
    function automatic ph_t ph_word(input logic got, input cnt_t cap);
        return {~got, (got ? cap : PPS_CNT_MAX)};
    endfunction

endpackage

// File: rtl/pps_phase_meas_if.sv
// Published measurement bundle towards the UART answer formatter.
interface pps_phase_meas_if;
    import pps_pkg::*;

    ph_t  o_ph1;
    ph_t  o_ph2;
    ph_t  o_ph3;
    ph_t  o_ph4;
    cnt_t o_freq;
    logic o_tx_start;

    modport master (
        output o_ph1, o_ph2, o_ph3, o_ph4, o_freq, o_tx_start
    );

    modport slave (
        input  o_ph1, o_ph2, o_ph3, o_ph4, o_freq, o_tx_start
    );

endinterface

// File: rtl/pps_edge_det.sv
// 2-FF synchronizer, optional deglitch filter (PPS_DEGLITCH_EN) and registered rising-edge pulse.
module pps_edge_det #(
    parameter int FILT_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic pps_i,
    output logic pulse_o
);

    logic [1:0] sync_q;
    logic       lvl;
    logic       lvl_prev_q;
    logic       pulse_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pps_i};
        end
    end

`ifdef PPS_DEGLITCH_EN
    localparam logic [7:0] FILT_INIT = 8'(FILT_LEN - 1);

    logic [7:0] filt_cnt_q, filt_cnt_d;
    logic       filt_q, filt_d;

    // Down-counter reloads on any low sample; output rises on the FILT_LEN-th high sample.
    always_comb begin
        filt_cnt_d = FILT_INIT;
        filt_d     = 1'b0;
        if (sync_q[1]) begin
            if (filt_cnt_q == 8'd0) begin
                filt_cnt_d = 8'd0;
                filt_d     = 1'b1;
            end else begin
                filt_cnt_d = filt_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            filt_cnt_q <= FILT_INIT;
            filt_q     <= 1'b0;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            filt_q     <= filt_d;
        end
    end

    assign lvl = filt_q;
`else
    localparam int unused_filt_len = FILT_LEN;

    assign lvl = sync_q[1];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lvl_prev_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            lvl_prev_q <= lvl;
            pulse_q    <= lvl & ~lvl_prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/pps_phase_meas.sv
// Phase of four PPS channels and period of the reference PPS, published once per reference second.
// Optional input deglitch filter enabled by defining PPS_DEGLITCH_EN.
module pps_phase_meas
    import pps_pkg::*;
#(
    parameter int FILT_LEN = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pps_ref,
    input  logic [PPS_NUM_CH-1:0] i_pps_ch,
    pps_phase_meas_if.master      out_if
);

    // state     | meaning
    // ARM_IDLE  | no valid window yet; next reference pulse arms without publishing
    // ARM_ARMED | a full window is in progress; next reference pulse publishes

    logic                  ref_pulse;
    logic [PPS_NUM_CH-1:0] ch_pulse;

    pps_edge_det #(.FILT_LEN(FILT_LEN)) u_ref_det (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .pps_i   (i_pps_ref),
        .pulse_o (ref_pulse)
    );

    for (genvar g = 0; g < PPS_NUM_CH; g++) begin : g_ch_det
        pps_edge_det #(.FILT_LEN(FILT_LEN)) u_ch_det (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .pps_i   (i_pps_ch[g]),
            .pulse_o (ch_pulse[g])
        );
    end

    arm_state_e            st_q, st_d;
    cnt_t                  r_cnt_q, r_cnt_d;
    cnt_t                  cnt_inc;
    logic [PPS_NUM_CH-1:0] got_q, got_d;
    cnt_t                  cap_q [PPS_NUM_CH];
    cnt_t                  cap_d [PPS_NUM_CH];
    ph_t                   ph_q  [PPS_NUM_CH];
    ph_t                   ph_d  [PPS_NUM_CH];
    cnt_t                  freq_q, freq_d;
    logic                  tx_q, tx_d;
    logic                  publish;

    always_comb begin
        st_d    = st_q;
        publish = 1'b0;
        case (st_q)
            ARM_IDLE: begin
                if (ref_pulse) begin
                    st_d = ARM_ARMED;
                end
            end
            ARM_ARMED: begin
                if (ref_pulse) begin
                    publish = 1'b1;
                end else if (r_cnt_q == PPS_CNT_MAX) begin
                    st_d = ARM_IDLE;
                end
            end
            default: st_d = ARM_IDLE;
        endcase
    end

    // cnt_inc is the phase of the current cycle relative to the last reference pulse.
    always_comb begin
        cnt_inc = sat_inc(r_cnt_q);
        r_cnt_d = ref_pulse ? '0 : cnt_inc;
        got_d   = got_q;
        cap_d   = cap_q;
        ph_d    = ph_q;
        freq_d  = freq_q;
        tx_d    = publish;

        if (publish) begin
            freq_d = cnt_inc;
            for (int n = 0; n < PPS_NUM_CH; n++) begin
                ph_d[n] = ph_word(got_q[n], cap_q[n]);
            end
        end

        // A channel pulse coincident with the reference pulse opens the new window at phase 0.
        for (int n = 0; n < PPS_NUM_CH; n++) begin
            if (ref_pulse) begin
                got_d[n] = ch_pulse[n];
                cap_d[n] = '0;
            end else if (ch_pulse[n] && !got_q[n]) begin
                got_d[n] = 1'b1;
                cap_d[n] = cnt_inc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q    <= ARM_IDLE;
            r_cnt_q <= '0;
            got_q   <= '0;
            freq_q  <= '0;
            tx_q    <= 1'b0;
            for (int n = 0; n < PPS_NUM_CH; n++) begin
                cap_q[n] <= '0;
                ph_q[n]  <= '0;
            end
        end else begin
            st_q    <= st_d;
            r_cnt_q <= r_cnt_d;
            got_q   <= got_d;
            freq_q  <= freq_d;
            tx_q    <= tx_d;
            cap_q   <= cap_d;
            ph_q    <= ph_d;
        end
    end

    assign out_if.o_ph1      = ph_q[0];
    assign out_if.o_ph2      = ph_q[1];
    assign out_if.o_ph3      = ph_q[2];
    assign out_if.o_ph4      = ph_q[3];
    assign out_if.o_freq     = freq_q;
    assign out_if.o_tx_start = tx_q;

endmodule

// File: doc/pps_phase_meas.md
# pps_phase_meas

Measures the phase of four PPS inputs against a reference PPS, and the reference period, in i_clk cycles. Sits directly upstream of the UART answer formatter. Once per reference second it publishes four 29-bit phase words and one 28-bit frequency word, with a one-cycle start strobe that triggers a transmission.

## Interface
- FILT_LEN, 8, stable-high cycles required by the deglitch filter (only used with PPS_DEGLITCH_EN); 2..255
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_pps_ref  in  1  reference PPS, asynchronous to i_clk
- i_pps_ch  in  4  channel PPS inputs 1..4, asynchronous to i_clk
- o_ph1..o_ph4  out  29 each  bit 28 = missing flag, bits 27:0 = phase count
- o_freq  out  28  i_clk cycles between the last two reference edges
- o_tx_start  out  1  one-cycle strobe; outputs are valid and stable while it is high

## Operation
- Every PPS input passes through a 2-FF synchronizer and then a rising-edge detector, giving a 1-cycle pulse. All five paths have identical latency, so latency cancels out of the phase.
- Counter r_cnt[27:0]:
  - loads 0 in the cycle of a reference pulse
  - otherwise increments by 1
  - saturates at 28'hFFFFFFF
- Window: the cycles from one reference pulse up to, but not including, the next one.
- Per channel, inside a window:
  - The first channel pulse captures r_cnt into cap_n and sets got_n.
  - Later pulses in the same window are ignored.
- Channel pulse in the same cycle as a reference pulse: it belongs to the new window and captures 0.
- Reference pulse while armed (publish):
  - o_freq = sat(r_cnt + 1), where sat limits the value to 28'hFFFFFFF
  - o_phN = {~got_N, got_N ? cap_N : 28'hFFFFFFF}
  - o_tx_start pulses
  - all got_N flags clear
- Arming:
  - Reset clears armed.
  - The first reference pulse only sets armed: no publish and no strobe.
  - If r_cnt saturates, armed clears, so the next reference pulse re-arms without publishing.
- No back-pressure. The downstream formatter finishes its frame well inside one second.

## Timing
- Reset values:
  - o_ph1..4 = 0
  - o_freq = 0
  - o_tx_start = 0
  - r_cnt = 0
  - got_N = 0
  - armed = 0
- Pin-to-pulse latency: 3 cycles (2 sync + 1 edge register). With PPS_DEGLITCH_EN, add FILT_LEN cycles.
- Publish latency:
  - Reference pulse in cycle N.
  - o_ph*, o_freq and o_tx_start are registered and updated in cycle N+1.
  - o_tx_start is high for exactly cycle N+1.
  - o_ph*/o_freq hold their values until the next publish.
- Phase resolution: 1 i_clk cycle. The phase for an edge arriving k cycles after the reference edge is k.
- Frequency: reference edges exactly P cycles apart give o_freq = P.
- Reset asserted mid-window: everything returns to reset values immediately. The strobe is suppressed until two reference pulses have occurred after reset release.

## Configuration
- PPS_DEGLITCH_EN defined:
  - After the synchronizer, each input goes through a filter. The filter output rises only after the synchronized input has been high for FILT_LEN consecutive cycles, and falls after one low cycle.
  - Shorter glitches produce no pulse.
- PPS_DEGLITCH_EN undefined: the synchronizer output feeds the edge detector directly, and FILT_LEN is ignored.

## Structure
- Shared package pps_pkg:
  - PPS_CNT_W = 28
  - PPS_PH_W = 29
  - PPS_NUM_CH = 4
  - PPS_CNT_MAX = 28'hFFFFFFF
- Sub-module pps_edge_det (synchronizer, optional filter, rising-edge pulse):
  - instantiated five times: ref plus four channels
  - holds the only PPS_DEGLITCH_EN-dependent logic

## Test plan
- Reference period 1000 cycles, ch1 delay 10, ch2 delay 0, ch3 delay 999, ch4 never toggles -> second publish gives:
  - o_freq = 1000
  - o_ph1 = 29'h000000A
  - o_ph2 = 0
  - o_ph3 = 29'h00003E7
  - o_ph4 = 29'h1FFFFFFF
  - o_tx_start = 1 for exactly 1 cycle
- First reference edge after reset -> no o_tx_start and outputs stay 0. Second edge -> publish.
- ch1 pulses twice in one window, at 5 and at 50 -> o_ph1 = 5.
- Reference held low for more than 2^28 cycles (force r_cnt near max) -> saturation disarms, and the next reference edge produces no strobe.
- Reset asserted 300 cycles into a window -> all outputs 0 at once, and no strobe until two reference edges after release.
- With PPS_DEGLITCH_EN and FILT_LEN = 8:
  - 5-cycle high glitch on ch1 at offset 20, then a real edge at 100 -> o_ph1 = 100
  - Without the macro, the same stimulus gives o_ph1 = 20.
